// File: rtl/text_slot_sequencer_pkg.sv
// Shared screen encoding, glyph IDs and per-screen layout for the text overlay.
package text_seq_pkg;

  typedef enum logic [1:0] {
    TITLE = 2'd0,
    MENU  = 2'd1,
    LEVEL = 2'd2,
    BLANK = 2'd3
  } screen_e;

  localparam logic [5:0] ID_BLANK = 6'd63;

  // "PLAY"
  localparam logic [5:0] ID_PLAY_P = 6'd0;
  // "LEVEL" letters occupy 4..8, digits 1..3 occupy 9..11
  localparam logic [5:0] ID_LVL_L  = 6'd4;
  localparam logic [5:0] ID_DIGIT1 = 6'd9;
  // "WHACK-A-MOLE"
  localparam logic [5:0] ID_W      = 6'd12;
  localparam logic [5:0] ID_H      = 6'd13;
  localparam logic [5:0] ID_A      = 6'd14;
  localparam logic [5:0] ID_C      = 6'd15;
  localparam logic [5:0] ID_K      = 6'd16;
  localparam logic [5:0] ID_A2     = 6'd17;
  localparam logic [5:0] ID_DASH   = 6'd18;
  localparam logic [5:0] ID_M      = 6'd19;
  localparam logic [5:0] ID_O      = 6'd20;
  localparam logic [5:0] ID_L      = 6'd21;
  localparam logic [5:0] ID_E      = 6'd22;

  localparam logic [9:0] X0_TITLE  = 10'd32;
  localparam logic [9:0] X0_MENU   = 10'd224;
  localparam logic [9:0] X0_LEVEL  = 10'd152;
  localparam logic [3:0] LEN_TITLE = 4'd12;
  localparam logic [3:0] LEN_MENU  = 4'd4;
  localparam logic [3:0] LEN_LEVEL = 4'd7;

  localparam logic [3:0] DIGIT_COL = 4'd6;

  function automatic logic [9:0] screen_x0(screen_e s);
    unique case (s)
      TITLE:   return X0_TITLE;
      MENU:    return X0_MENU;
      LEVEL:   return X0_LEVEL;
      default: return 10'd0;
    endcase
  endfunction

  // Index of the final slot; BLANK never starts a run so its value is unused.
  function automatic logic [3:0] screen_last(screen_e s);
    unique case (s)
      TITLE:   return LEN_TITLE - 4'd1;
      MENU:    return LEN_MENU - 4'd1;
      LEVEL:   return LEN_LEVEL - 4'd1;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/text_slot_sequencer_if.sv
// Timing-generator side (master) to sequencer (slave) bundle.
interface text_slot_sequencer_if;
  logic       pix_en;
  logic       frame_start;
  logic [9:0] x;
  logic [8:0] y;
  logic [1:0] screen_sel;
  logic [1:0] level;
  logic [9:0] x_d;
  logic [8:0] y_d;
  logic [5:0] id;
  logic [9:0] xstart;
  logic [8:0] ystart;
  logic [6:0] lwidth;
  logic [6:0] lheight;
  logic       slot_valid;
  logic       blink_on;

  modport master (
    output pix_en, frame_start, x, y, screen_sel, level,
    input  x_d, y_d, id, xstart, ystart, lwidth, lheight, slot_valid, blink_on
  );

  modport slave (
    input  pix_en, frame_start, x, y, screen_sel, level,
    output x_d, y_d, id, xstart, ystart, lwidth, lheight, slot_valid, blink_on
  );
endinterface

// File: rtl/text_slot_sequencer_msg_rom.sv
// Message table: maps (screen, slot column, level) to a glyph ID; blank marks empty slots.
module msg_rom
  import text_seq_pkg::*;
(
  input  screen_e    screen,
  input  logic [3:0] col,
  input  logic [1:0] level,
  output logic [5:0] id,
  output logic       blank
);

  // Per-screen lookup; anything past the message end is blank.
  always_comb begin
    id    = ID_BLANK;
    blank = 1'b1;
    unique case (screen)
      TITLE: begin
        blank = 1'b0;
        case (col)
          4'd0:    id = ID_W;
          4'd1:    id = ID_H;
          4'd2:    id = ID_A;
          4'd3:    id = ID_C;
          4'd4:    id = ID_K;
          4'd5:    id = ID_DASH;
          4'd6:    id = ID_A2;
          4'd7:    id = ID_DASH;
          4'd8:    id = ID_M;
          4'd9:    id = ID_O;
          4'd10:   id = ID_L;
          4'd11:   id = ID_E;
          default: blank = 1'b1;
        endcase
      end
      MENU: begin
        if (col < LEN_MENU) begin
          id    = ID_PLAY_P + {2'b00, col};
          blank = 1'b0;
        end
      end
      LEVEL: begin
        if (col < 4'd5) begin
          id    = ID_LVL_L + {2'b00, col};
          blank = 1'b0;
        end else if (col == DIGIT_COL) begin
          // level is stored as 1..3 so digit IDs are 9..11
          id    = ID_DIGIT1 + {4'd0, level} - 6'd1;
          blank = 1'b0;
        end
      end
      default: ;
    endcase
    if (blank) id = ID_BLANK;
  end

endmodule

// File: rtl/text_slot_sequencer.sv
// Per-pixel character-slot sequencer: walks the active message's slots along the text row
// and presents glyph ID / origin / size one pix_en strobe after the pixel coordinates.
module text_slot_sequencer
  import text_seq_pkg::*;
#(
  parameter int unsigned CHAR_W = 40,
  parameter int unsigned CHAR_H = 60,
  parameter int unsigned PITCH  = 48,
  parameter int unsigned ROW_Y  = 200
) (
  input logic                   clk,
  input logic                   rst_n,
  text_slot_sequencer_if.slave  bus
);

  typedef enum logic {StIdle, StRun} walk_e;

  localparam logic [5:0] PITCH_M1 = 6'(PITCH - 1);
  localparam logic [9:0] PITCH_X  = 10'(PITCH);

  screen_e    screen_q;
  logic [1:0] level_q;
  logic [5:0] frame_cnt_q;

  walk_e      state_q, state_d;
  logic [5:0] px_q, px_d;
  logic [3:0] col_q, col_d;
  logic [9:0] acc_q, acc_d;

  logic       row_hit;
  logic [9:0] x0_cur;
  logic [3:0] last_col;
  logic [5:0] rom_id;
  logic       rom_blank;
  logic       blink_gate;

  assign row_hit  = (32'(bus.y) >= ROW_Y) && (32'(bus.y) < ROW_Y + CHAR_H);
  assign x0_cur   = screen_x0(screen_q);
  assign last_col = screen_last(screen_q);

  // ROM looks up the slot the walker is about to occupy so outputs align with x_d.
  msg_rom u_msg_rom (
    .screen (screen_q),
    .col    (col_d),
    .level  (level_q),
    .id     (rom_id),
    .blank  (rom_blank)
  );

  assign blink_gate = !((screen_q == LEVEL) && (col_d == DIGIT_COL) && !frame_cnt_q[5]);

  assign bus.blink_on = frame_cnt_q[5];
  assign bus.lwidth   = 7'(CHAR_W);
  assign bus.lheight  = 7'(CHAR_H);

  // Frame-level registers: screen/level latch only at frame start so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      screen_q    <= TITLE;
      level_q     <= 2'd1;
      frame_cnt_q <= 6'd0;
    end else if (bus.pix_en && bus.frame_start) begin
      screen_q    <= screen_e'(bus.screen_sel);
      level_q     <= (bus.level == 2'd0) ? 2'd1 : bus.level;
      frame_cnt_q <= frame_cnt_q + 6'd1;
    end
  end

  // Slot walker next state: start on x0 match inside the row, step slots by pitch.
  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    col_d   = col_q;
    acc_d   = acc_q;
    unique case (state_q)
      StIdle: begin
        if ((screen_q != BLANK) && row_hit && (bus.x == x0_cur)) begin
          state_d = StRun;
          px_d    = 6'd0;
          col_d   = 4'd0;
          acc_d   = x0_cur;
        end
      end
      StRun: begin
        if ((bus.x >= 10'd640) || ((col_q == last_col) && (px_q == PITCH_M1))) begin
          state_d = StIdle;
        end else if (px_q == PITCH_M1) begin
          px_d  = 6'd0;
          col_d = col_q + 4'd1;
          acc_d = acc_q + PITCH_X;
        end else begin
          px_d = px_q + 6'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Walker state and all pixel-aligned outputs advance together on pix_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      px_q           <= 6'd0;
      col_q          <= 4'd0;
      acc_q          <= 10'd0;
      bus.x_d        <= 10'd0;
      bus.y_d        <= 9'd0;
      bus.id         <= 6'd0;
      bus.xstart     <= 10'd0;
      bus.ystart     <= 9'd0;
      bus.slot_valid <= 1'b0;
    end else if (bus.pix_en) begin
      state_q        <= state_d;
      px_q           <= px_d;
      col_q          <= col_d;
      acc_q          <= acc_d;
      bus.x_d        <= bus.x;
      bus.y_d        <= bus.y;
      bus.id         <= rom_id;
      bus.xstart     <= acc_d;
      bus.ystart     <= 9'(ROW_Y);
      bus.slot_valid <= (state_d == StRun) && !rom_blank && blink_gate;
    end
  end

endmodule

// File: tb/tb_text_slot_sequencer.sv
// Self-checking bench: randomized pixel sweeps against a slot-layout reference model.
module tb_text_slot_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  text_slot_sequencer_if bus ();

  text_slot_sequencer #(
    .CHAR_W (40),
    .CHAR_H (60),
    .PITCH  (48),
    .ROW_Y  (200)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_screen = 0, m_level = 1, m_frame = 0;
  int sel_req = 0, lvl_req = 0;
  int title_tab [12] = '{12, 13, 14, 15, 16, 18, 17, 18, 19, 20, 21, 22};

  logic       obs_v  [800];
  logic [5:0] obs_id [800];
  logic [9:0] obs_xs [800];

  function automatic int x0_of(int s);
    case (s)
      0: return 32;
      1: return 224;
      2: return 152;
      default: return 1000;
    endcase
  endfunction

  function automatic int len_of(int s);
    case (s)
      0: return 12;
      1: return 4;
      2: return 7;
      default: return 0;
    endcase
  endfunction

  function automatic int glyph(int s, int slot, int l);
    case (s)
      0: return title_tab[slot];
      1: return slot;
      2: begin
        if (slot < 5) return 4 + slot;
        if (slot == 6) return 8 + l;
        return -1;
      end
      default: return -1;
    endcase
  endfunction

  function automatic bit exp_valid(int xv, int yv, int s, int l, int f);
    int x0, slot;
    if (s == 3 || yv < 200 || yv >= 260) return 1'b0;
    x0 = x0_of(s);
    if (xv < x0 || xv >= x0 + len_of(s) * 48) return 1'b0;
    slot = (xv - x0) / 48;
    if (glyph(s, slot, l) < 0) return 1'b0;
    if (s == 2 && slot == 6 && f < 32) return 1'b0;
    return 1'b1;
  endfunction

  task automatic set_req(input int s, input int l);
    sel_req = s;
    lvl_req = l;
    bus.screen_sel = 2'(s);
    bus.level = 2'(l);
  endtask

  task automatic strobe(input int xv, input int yv, input bit fs);
    bus.x = 10'(xv);
    bus.y = 9'(yv);
    bus.frame_start = fs;
    bus.pix_en = 1'b1;
    @(posedge clk);
    #1;
    bus.pix_en = 1'b0;
    bus.frame_start = 1'b0;
    if (fs) begin
      m_screen = sel_req;
      m_level = (lvl_req == 0) ? 1 : lvl_req;
      m_frame = (m_frame + 1) % 64;
    end
  endtask

  task automatic frame_pulse();
    strobe(0, 0, 1'b1);
  endtask

  // Scenario: sweep one line, compare every pixel with the model, with random pix_en gaps.
  task automatic check_sweep(input string name, input int yv, input int xlo, input int xhi);
    int s, l, f, slot, exs, n;
    bit ev;
    logic [5:0] eid;
    s = m_screen;
    l = m_level;
    f = m_frame;
    for (int xv = xlo; xv <= xhi; xv++) begin
      strobe(xv, yv, 1'b0);
      obs_v[xv] = bus.slot_valid;
      obs_id[xv] = bus.id;
      obs_xs[xv] = bus.xstart;
      ev = exp_valid(xv, yv, s, l, f);
      checks++;
      if (bus.slot_valid !== ev || bus.x_d !== 10'(xv) || bus.y_d !== 9'(yv) ||
          bus.ystart !== 9'd200) begin
        failures++;
        $display("FAIL %s x=%0d y=%0d: got valid=%b x_d=%0d y_d=%0d ystart=%0d, want valid=%b",
                 name, xv, yv, bus.slot_valid, bus.x_d, bus.y_d, bus.ystart, ev);
      end
      if (ev) begin
        slot = (xv - x0_of(s)) / 48;
        eid = 6'(glyph(s, slot, l));
        exs = x0_of(s) + slot * 48;
        checks++;
        if (bus.id !== eid || bus.xstart !== 10'(exs)) begin
          failures++;
          $display("FAIL %s_slot x=%0d: got id=%0d xstart=%0d, want id=%0d xstart=%0d",
                   name, xv, bus.id, bus.xstart, eid, exs);
        end
      end
      if ($urandom_range(7) == 0) begin
        n = $urandom_range(3, 1);
        repeat (n) begin
          bus.x = 10'($urandom_range(799));
          bus.y = 9'($urandom_range(511));
          @(posedge clk);
          #1;
          checks++;
          if (bus.slot_valid !== obs_v[xv] || bus.id !== obs_id[xv] ||
              bus.xstart !== obs_xs[xv] || bus.x_d !== 10'(xv)) begin
            failures++;
            $display("FAIL %s_hold x=%0d: got valid=%b id=%0d xstart=%0d x_d=%0d",
                     name, xv, bus.slot_valid, bus.id, bus.xstart, bus.x_d);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    bus.pix_en = 1'b0;
    bus.frame_start = 1'b0;
    bus.x = '0;
    bus.y = '0;
    set_req(0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.x_d !== 10'd0 || bus.y_d !== 9'd0 || bus.id !== 6'd0) begin
      failures++;
      $display("FAIL reset_coords got x_d=%0d y_d=%0d id=%0d want 0 0 0", bus.x_d, bus.y_d, bus.id);
    end
    checks++;
    if (bus.xstart !== 10'd0 || bus.ystart !== 9'd0) begin
      failures++;
      $display("FAIL reset_origin got xstart=%0d ystart=%0d want 0 0", bus.xstart, bus.ystart);
    end
    checks++;
    if (bus.slot_valid !== 1'b0 || bus.blink_on !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got valid=%b blink=%b want 0 0", bus.slot_valid, bus.blink_on);
    end
    checks++;
    if (bus.lwidth !== 7'd40 || bus.lheight !== 7'd60) begin
      failures++;
      $display("FAIL size got lwidth=%0d lheight=%0d want 40 60", bus.lwidth, bus.lheight);
    end
    #3 rst_n = 1'b1;
    m_screen = 0;
    m_level = 1;
    m_frame = 0;
  endtask

  task automatic test_title();
    int cnt = 0;
    check_sweep("title", 210, 0, 639);
    for (int i = 0; i < 640; i++) if (obs_v[i] === 1'b1) cnt++;
    checks++;
    if (cnt != 576) begin
      failures++;
      $display("FAIL title_count got %0d want 576", cnt);
    end
    checks++;
    if (obs_v[31] !== 1'b0 || obs_v[608] !== 1'b0 || obs_id[32] !== 6'd12) begin
      failures++;
      $display("FAIL title_edges got v31=%b v608=%b id32=%0d want 0 0 12",
               obs_v[31], obs_v[608], obs_id[32]);
    end
    checks++;
    if (obs_id[607] !== 6'd22 || obs_xs[607] !== 10'd560) begin
      failures++;
      $display("FAIL title_last got id=%0d xstart=%0d want 22 560", obs_id[607], obs_xs[607]);
    end
  endtask

  task automatic test_menu_switch();
    int cnt = 0;
    set_req(1, 0);
    check_sweep("menu_held", 210, 0, 639);
    checks++;
    if (obs_id[32] !== 6'd12 || obs_v[224] !== 1'b1) begin
      failures++;
      $display("FAIL menu_held got id32=%0d v224=%b want 12 1", obs_id[32], obs_v[224]);
    end
    frame_pulse();
    check_sweep("menu", 230, 0, 639);
    for (int i = 0; i < 640; i++) if (obs_v[i] === 1'b1) cnt++;
    checks++;
    if (cnt != 192 || obs_id[224] !== 6'd0 || obs_xs[224] !== 10'd224) begin
      failures++;
      $display("FAIL menu_first got count=%0d id=%0d xstart=%0d want 192 0 224",
               cnt, obs_id[224], obs_xs[224]);
    end
    checks++;
    if (obs_id[400] !== 6'd3 || obs_xs[400] !== 10'd368 || obs_xs[300] !== 10'd272) begin
      failures++;
      $display("FAIL menu_slots got id400=%0d xs400=%0d xs300=%0d want 3 368 272",
               obs_id[400], obs_xs[400], obs_xs[300]);
    end
  endtask

  task automatic test_level0();
    set_req(2, 0);
    frame_pulse();
    check_sweep("level0", 240, 0, 639);
    checks++;
    if (obs_id[440] !== 6'd9 || obs_xs[440] !== 10'd440) begin
      failures++;
      $display("FAIL level0_digit got id=%0d xstart=%0d want 9 440", obs_id[440], obs_xs[440]);
    end
    checks++;
    if (obs_v[392] !== 1'b0 || obs_v[420] !== 1'b0 || obs_v[160] !== 1'b1) begin
      failures++;
      $display("FAIL level0_gap got v392=%b v420=%b v160=%b want 0 0 1",
               obs_v[392], obs_v[420], obs_v[160]);
    end
  endtask

  task automatic test_blink();
    bit want;
    set_req(2, 3);
    for (int i = 0; i < 64; i++) begin
      frame_pulse();
      want = (m_frame >= 32);
      checks++;
      if (bus.blink_on !== want) begin
        failures++;
        $display("FAIL blink_on frame=%0d got %b want %b", m_frame, bus.blink_on, want);
      end
      check_sweep("blink", $urandom_range(259, 200), 140, 495);
      checks++;
      if (obs_v[450] !== want || obs_id[450] !== 6'd11 || obs_v[300] !== 1'b1) begin
        failures++;
        $display("FAIL blink_digit frame=%0d got v=%b id=%0d v300=%b want %b 11 1",
                 m_frame, obs_v[450], obs_id[450], bus.slot_valid, want);
      end
    end
  endtask

  task automatic test_same_strobe();
    // LEVEL is active; request TITLE and pulse frame_start on LEVEL's x0 inside the row
    set_req(0, 1);
    strobe(152, 210, 1'b1);
    checks++;
    if (bus.slot_valid !== 1'b1 || bus.id !== 6'd4 || bus.xstart !== 10'd152) begin
      failures++;
      $display("FAIL same_strobe got valid=%b id=%0d xstart=%0d want 1 4 152",
               bus.slot_valid, bus.id, bus.xstart);
    end
    strobe(700, 210, 1'b0);
    check_sweep("after_switch", 215, 0, 639);
  endtask

  task automatic test_blank_rows();
    int cnt = 0;
    check_sweep("row199", 199, 0, 639);
    for (int i = 0; i < 640; i++) if (obs_v[i] === 1'b1) cnt++;
    check_sweep("row260", 260, 0, 639);
    for (int i = 0; i < 640; i++) if (obs_v[i] === 1'b1) cnt++;
    set_req(3, 2);
    frame_pulse();
    check_sweep("screen3", 210, 0, 639);
    for (int i = 0; i < 640; i++) if (obs_v[i] === 1'b1) cnt++;
    checks++;
    if (cnt != 0) begin
      failures++;
      $display("FAIL blank_rows got %0d valid pixels want 0", cnt);
    end
  endtask

  task automatic test_reset_midline();
    int cnt = 0;
    set_req(0, 0);
    frame_pulse();
    check_sweep("pre_reset", 210, 0, 300);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.slot_valid !== 1'b0 || bus.id !== 6'd0 || bus.xstart !== 10'd0 ||
        bus.x_d !== 10'd0 || bus.y_d !== 9'd0 || bus.ystart !== 9'd0) begin
      failures++;
      $display("FAIL async_reset got valid=%b id=%0d xstart=%0d x_d=%0d y_d=%0d ystart=%0d",
               bus.slot_valid, bus.id, bus.xstart, bus.x_d, bus.y_d, bus.ystart);
    end
    #2 rst_n = 1'b1;
    m_screen = 0;
    m_level = 1;
    m_frame = 0;
    for (int xv = 301; xv < 640; xv++) begin
      strobe(xv, 210, 1'b0);
      if (bus.slot_valid === 1'b1) cnt++;
    end
    checks++;
    if (cnt != 0) begin
      failures++;
      $display("FAIL reset_rest_of_line got %0d valid pixels want 0", cnt);
    end
    check_sweep("after_reset", 211, 0, 639);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      set_req($urandom_range(3), $urandom_range(3));
      frame_pulse();
      check_sweep("random", $urandom_range(265, 195), 0, 639);
    end
  endtask

  initial begin
    test_reset();
    test_title();
    test_menu_switch();
    test_level0();
    test_blink();
    test_same_strobe();
    test_blank_rows();
    test_reset_midline();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/text_slot_sequencer.md
# text_slot_sequencer

Per-pixel character-slot sequencer for the VGA text overlay. Sits between the VGA timing generator and the combinational glyph mapper. For every active pixel it determines which character slot of the current screen's message the pixel falls in. It then presents that slot's glyph ID, origin and size, together with pixel-aligned coordinates, to the glyph mapper. It also owns the on-screen message selection (title / menu / level) and the level-digit blink.

## Interface
Parameters:
- CHAR_W, 40, glyph box width in pixels (drives lwidth)
- CHAR_H, 60, glyph box height in pixels (drives lheight)
- PITCH, 48, horizontal slot pitch in pixels (CHAR_W + 8 gap)
- ROW_Y, 200, top y of the text row

Ports:
- clk  in  1  pixel-domain system clock
- rst_n  in  1  reset; asynchronous, active-low
- pix_en  in  1  one-cycle pixel strobe; all state advances only when high
- frame_start  in  1  one-cycle pulse at start of each frame
- x  in  10  current pixel column (0–799, active 0–639)
- y  in  9  current pixel row (active 0–479)
- screen_sel  in  2  requested screen: 0 TITLE, 1 MENU, 2 LEVEL, 3 reserved (blank)
- level  in  2  level to show on LEVEL screen; 0 is displayed as 1
- x_d  out  10  x delayed to align with slot outputs
- y_d  out  9  y delayed to align with slot outputs
- id  out  6  glyph ID for the glyph mapper
- xstart  out  10  slot origin x
- ystart  out  9  slot origin y (= ROW_Y when valid)
- lwidth  out  7  = CHAR_W
- lheight  out  7  = CHAR_H
- slot_valid  out  1  pixel lies in a non-blank slot; downstream gates the glyph output with it
- blink_on  out  1  current blink phase

## Operation
- Messages, as glyph IDs:
  - TITLE "WHACK-A-MOLE": 12,13,14,15,16,18,17,18,19,20,21,22 (12 slots, x0 = 32).
  - MENU "PLAY": 0,1,2,3 (4 slots, x0 = 224).
  - LEVEL "LEVEL n": 4,5,6,7,8, blank, digit (7 slots, x0 = 152). The digit is 9/10/11 for level 1/2/3.
- Frame registers update only on frame_start & pix_en:
  - active_screen ← screen_sel.
  - level_r ← level (0 stored as 1).
  - frame_cnt (6 bit) ← frame_cnt + 1, wrapping 63→0.
- blink_on = frame_cnt[5]. On the LEVEL screen, the digit slot's slot_valid is forced low while blink_on = 0.
- Slot walker state machine, advancing on pix_en:
  - IDLE → RUN when y is in [ROW_Y, ROW_Y+CHAR_H) and x == x0(active_screen). Sets px = 0, col = 0, xstart_acc = x0.
  - In RUN, px increments. When px == PITCH−1, px ← 0, col ← col+1 and xstart_acc ← xstart_acc + PITCH (accumulator, no multiplier).
  - RUN → IDLE when col == len−1 and px == PITCH−1, or when x ≥ 640.
- Registered outputs, updated on pix_en:
  - x_d, y_d ← x, y.
  - id ← ROM(active_screen, col, level_r).
  - xstart ← xstart_acc.
  - ystart ← ROW_Y.
  - slot_valid ← (next state RUN) & slot not blank & blink gate.
- Screen 3: the walker never leaves IDLE and slot_valid stays 0.
- lwidth and lheight are constant CHAR_W and CHAR_H.

## Timing
- Latency: exactly one pix_en strobe from (x, y) in to (x_d, y_d, id, xstart, slot_valid) out. All outputs are mutually aligned.
- Outputs hold their value between pix_en strobes.
- Reset values: x_d = 0, y_d = 0, id = 0, xstart = 0, ystart = 0, slot_valid = 0, blink_on = 0. lwidth and lheight are constants. Internal reset values: active_screen = TITLE, level_r = 1, frame_cnt = 0, walker IDLE.
- Asynchronous reset mid-line: outputs clear immediately. The walker restarts only at the next x0 match.
- frame_start and a row start in the same strobe: the walker uses the old active_screen. The new screen takes effect from the next strobe.
- A screen_sel change mid-frame is ignored until the next frame_start, so a frame never tears.
- pix_en low: no state change at all, including frame_start being ignored.
- A missing x0 match (e.g. x jumps) leaves the walker in IDLE for that line.

## Structure
- Package text_seq_pkg holds:
  - screen enum (TITLE, MENU, LEVEL, BLANK);
  - glyph ID constants;
  - per-screen x0 and length constants;
  - ID_BLANK = 6'd63.
- Sub-module msg_rom: combinational (screen, col, level) → (id, blank). Out-of-range col returns blank.

## Test plan
- Reset, then TITLE screen, y = 210, sweep x 0–639 → slot_valid high for x_d 32..607; id steps 12,13,…,22; xstart steps 32, 80, …, 560.
- screen_sel = 1 asserted mid-frame → output unchanged until frame_start. The next frame shows ids 0–3 at xstart 224, 272, 320, 368.
- LEVEL screen, level = 0 → digit slot id = 9 at xstart 440. Slot 5 (xstart 392) has slot_valid = 0.
- LEVEL screen, level = 3, 64 frame_start pulses → digit slot_valid low for frames 0–31 and high for frames 32–63. Other slots are unaffected.
- y = 199 and y = 260 → slot_valid never high. screen_sel = 3 → slot_valid never high.
- rst_n pulled low at x = 300 on the TITLE row → all outputs are 0 within the same cycle. After release the walker resumes on the next line at x0.
